conv_window_gen: RTL and testbench



---
 rtl/conv_win_pkg.sv | 25 ++
 rtl/lb_2row.sv | 37 +++
 rtl/conv_window_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_win_pkg.sv
// Shared constants and types for the 3x3 convolution-window generator.
package conv_win_pkg;

  localparam int K    = 3;
  localparam int TAPS = K * K;

  // Tap numbering inside one channel's window: row-major, top-left first.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  // Scan phase: real pixels, the virtual pad column, the virtual pad row.
  typedef enum logic [1:0] {
    STREAM  = 2'd0,
    PAD_COL = 2'd1,
    PAD_ROW = 2'd2
  } state_t;

endpackage

// File: rtl/lb_2row.sv
// Two-row line buffer. At a given column it returns the samples of the two
// previous rows (read before write), then shifts the column up by one row
// and stores the incoming pixel in the lower row.
module lb_2row #(
  parameter int CH   = 64,
  parameter int DW   = 16,
  parameter int FM_W = 56
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [$clog2(FM_W)-1:0]   addr,
  input  logic [CH*DW-1:0]          wr_data,
  output logic [CH*DW-1:0]          rd_top,
  output logic [CH*DW-1:0]          rd_mid
);

  logic [CH*DW-1:0] row_top [FM_W];
  logic [CH*DW-1:0] row_mid [FM_W];

  // Column update on a real-pixel step: mid row moves up, new pixel lands in mid.
  // NOTE: storage has no reset; the top level masks every tap whose row has not
  // been written in the current frame, so power-up contents are never visible.
  // NOTE: non-blocking assignments here so row_top captures row_mid's old value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      row_top[addr] <= row_mid[addr];
      row_mid[addr] <= wr_data;
    end
  end

  // Asynchronous read of the same column, giving the pre-write contents.
  always_comb begin
    rd_top = row_top[addr];
    rd_mid = row_mid[addr];
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator with zero padding of 1, stride 1 or 2,
// valid/ready on both sides. A scan covers FM_H+1 rows by FM_W+1 columns; the
// extra row and column are virtual pad steps that flush the bottom/right edge.
module conv_window_gen
  import conv_win_pkg::*;
#(
  parameter int CH     = 64,
  parameter int DW     = 16,
  parameter int FM_W   = 56,
  parameter int FM_H   = 56,
  parameter int STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      vs,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH*DW-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*TAPS*DW-1:0]     out_data,
  output logic [$clog2(FM_H)-1:0]   out_row,
  output logic [$clog2(FM_W)-1:0]   out_col,
  output logic                      out_last,
  output logic                      frame_done
);

  localparam int PW  = CH * DW;
  localparam int RW  = $clog2(FM_H + 1);
  localparam int CW  = $clog2(FM_W + 1);
  localparam int AW  = $clog2(FM_W);
  localparam int ORW = $clog2(FM_H);
  localparam int OCW = $clog2(FM_W);
  localparam int SH  = (STRIDE == 2) ? 1 : 0;

  localparam logic [RW-1:0] ROW_LAST = RW'(FM_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(FM_W - 1);
  localparam logic [CW-1:0] COL_PAD  = CW'(FM_W);
  localparam logic [RW-1:0] LAST_CR  = RW'(((FM_H - 1) / STRIDE) * STRIDE);
  localparam logic [CW-1:0] LAST_CC  = CW'(((FM_W - 1) / STRIDE) * STRIDE);

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              adv, step, emit, real_col;
  logic [RW-1:0]     cen_row;
  logic [CW-1:0]     cen_col;
  logic [AW-1:0]     lb_addr;
  logic [PW-1:0]     lb_top, lb_mid;
  logic [PW-1:0]     new_col [K];
  logic [PW-1:0]     wc0     [K];
  logic [PW-1:0]     wc1     [K];
  logic [PW-1:0]     col_l   [K];
  logic [PW-1:0]     col_c   [K];
  logic [PW-1:0]     col_r   [K];
  logic [CH*TAPS*DW-1:0] win_d;

  // State register; vs returns the scan to the start of a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   state_q <= STREAM;
    else if (vs) state_q <= STREAM;
    else         state_q <= state_d;
  end

  // Next-state: advance phase only on a step.
  // NOTE: every always_comb assigns its outputs a default first, so no branch
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (step) begin
      case (state_q)
        STREAM:  if (col_q == COL_LAST) state_d = PAD_COL;
        PAD_COL: state_d = (row_q < ROW_LAST) ? STREAM : PAD_ROW;
        PAD_ROW: if (col_q == COL_PAD) state_d = STREAM;
        default: state_d = STREAM;
      endcase
    end
  end

  // Handshake and step qualification; pad steps need only output room.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv && (state_q == STREAM) && !vs;
    step     = (state_q == STREAM) ? (in_valid && in_ready) : (adv && !vs);
  end

  // Scan position counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else if (vs) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step) begin
      case (state_q)
        STREAM: col_q <= (col_q == COL_LAST) ? COL_PAD : col_q + CW'(1);
        PAD_COL: begin
          row_q <= row_q + RW'(1);
          col_q <= '0;
        end
        PAD_ROW: begin
          if (col_q == COL_PAD) begin
            row_q <= '0;
            col_q <= '0;
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: begin
          row_q <= '0;
          col_q <= '0;
        end
      endcase
    end
  end

  assign lb_addr = real_col ? AW'(col_q) : '0;

  lb_2row #(
    .CH   (CH),
    .DW   (DW),
    .FM_W (FM_W)
  ) u_lb (
    .clk     (clk),
    .wr_en   (step && (state_q == STREAM)),
    .addr    (lb_addr),
    .wr_data (in_data),
    .rd_top  (lb_top),
    .rd_mid  (lb_mid)
  );

  // Incoming column {row-2, row-1, row} with rows outside the frame zeroed;
  // rows above the current frame may hold stale line-buffer data.
  always_comb begin
    real_col   = (col_q != COL_PAD);
    new_col[0] = (real_col && row_q >= RW'(2)) ? lb_top : '0;
    new_col[1] = (real_col && row_q >= RW'(1)) ? lb_mid : '0;
    new_col[2] = (state_q == STREAM) ? in_data : '0;
  end

  // Emission decision for the window centred at (row_q-1, col_q-1).
  always_comb begin
    cen_row = row_q - RW'(1);
    cen_col = col_q - CW'(1);
    emit    = step && (row_q != '0) && (col_q != '0) &&
              ((STRIDE == 1) || (!cen_row[0] && !cen_col[0]));
  end

  // Two stored columns of the sliding window; the third is new_col.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < K; r++) begin
        wc0[r] <= '0;
        wc1[r] <= '0;
      end
    end else if (vs) begin
      for (int r = 0; r < K; r++) begin
        wc0[r] <= '0;
        wc1[r] <= '0;
      end
    end else if (step) begin
      for (int r = 0; r < K; r++) begin
        wc0[r] <= wc1[r];
        wc1[r] <= new_col[r];
      end
    end
  end

  // Assemble the window with left/top edge masking and pack per channel.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col_l[r] = (col_q != CW'(1)) ? wc0[r] : '0;
      col_c[r] = wc1[r];
      col_r[r] = new_col[r];
    end
    if (row_q == RW'(1)) begin
      col_l[0] = '0;
      col_c[0] = '0;
      col_r[0] = '0;
    end
    win_d = '0;
    for (int c = 0; c < CH; c++) begin
      win_d[(c*TAPS + TAP_TL)*DW +: DW] = col_l[0][c*DW +: DW];
      win_d[(c*TAPS + TAP_TC)*DW +: DW] = col_c[0][c*DW +: DW];
      win_d[(c*TAPS + TAP_TR)*DW +: DW] = col_r[0][c*DW +: DW];
      win_d[(c*TAPS + TAP_ML)*DW +: DW] = col_l[1][c*DW +: DW];
      win_d[(c*TAPS + TAP_MC)*DW +: DW] = col_c[1][c*DW +: DW];
      win_d[(c*TAPS + TAP_MR)*DW +: DW] = col_r[1][c*DW +: DW];
      win_d[(c*TAPS + TAP_BL)*DW +: DW] = col_l[2][c*DW +: DW];
      win_d[(c*TAPS + TAP_BC)*DW +: DW] = col_c[2][c*DW +: DW];
      win_d[(c*TAPS + TAP_BR)*DW +: DW] = col_r[2][c*DW +: DW];
    end
  end

  // Output register: load on emission, hold while stalled, drop on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (vs) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= win_d;
        out_row   <= ORW'(cen_row >> SH);
        out_col   <= OCW'(cen_col >> SH);
        out_last  <= (cen_row == LAST_CR) && (cen_col == LAST_CC);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: three instances (4x4 stride 1,
// 4x4 stride 2, 5x3 stride 1), CH=1, DW=8, pixel value = offset+10*r+c.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int WB = 9 * DW;

  typedef struct {
    logic [WB-1:0] data;
    logic [2:0]    row;
    logic [2:0]    col;
    logic          last;
  } cap_t;

  typedef struct {
    logic [WB-1:0] data;
    logic          rdy;
    int            idx;
  } stl_t;

  logic          clk;
  logic          rstn;
  logic [2:0]    vs_v;
  logic [2:0]    iv;
  logic [2:0]    ordy;
  logic [DW-1:0] i_data [3];
  wire  [2:0]    ir;
  wire  [2:0]    ov;
  wire  [2:0]    olast;
  wire  [2:0]    fdone;
  wire  [WB-1:0] o_data [3];
  wire  [1:0]    r0, c0, r1, c1, r2;
  wire  [2:0]    c2;
  wire  [2:0]    o_row [3];
  wire  [2:0]    o_col [3];

  assign o_row[0] = {1'b0, r0};
  assign o_col[0] = {1'b0, c0};
  assign o_row[1] = {1'b0, r1};
  assign o_col[1] = {1'b0, c1};
  assign o_row[2] = {1'b0, r2};
  assign o_col[2] = c2;

  int   n_cmp = 0;
  int   n_bad = 0;
  cap_t cap_q[$];
  stl_t stl_q[$];
  bit   timed_out;
  int   fd_cnt, rdy_low, rdy_run_max;

  conv_window_gen #(.CH(1), .DW(DW), .FM_W(4), .FM_H(4), .STRIDE(1)) u_s1 (
    .clk(clk), .rstn(rstn), .vs(vs_v[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(i_data[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(o_data[0]),
    .out_row(r0), .out_col(c0), .out_last(olast[0]), .frame_done(fdone[0]));

  conv_window_gen #(.CH(1), .DW(DW), .FM_W(4), .FM_H(4), .STRIDE(2)) u_s2 (
    .clk(clk), .rstn(rstn), .vs(vs_v[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(i_data[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(o_data[1]),
    .out_row(r1), .out_col(c1), .out_last(olast[1]), .frame_done(fdone[1]));

  conv_window_gen #(.CH(1), .DW(DW), .FM_W(5), .FM_H(3), .STRIDE(1)) u_r (
    .clk(clk), .rstn(rstn), .vs(vs_v[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(i_data[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(o_data[2]),
    .out_row(r2), .out_col(c2), .out_last(olast[2]), .frame_done(fdone[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference window: zero outside the w x h frame.
  function automatic logic [WB-1:0] model_win(int w, int h, int off, int r, int c);
    logic [WB-1:0] v;
    int rr, cc;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r - 1 + k / 3;
      cc = c - 1 + k % 3;
      if (rr >= 0 && rr < h && cc >= 0 && cc < w) v[k*DW +: DW] = DW'(off + 10*rr + cc);
    end
    return v;
  endfunction

  // Expected i-th window of a frame in raster order.
  function automatic cap_t exp_cap(int w, int h, int s, int off, int i, int n);
    cap_t e;
    int nc, r, c;
    nc     = (w + s - 1) / s;
    r      = (i / nc) * s;
    c      = (i % nc) * s;
    e.data = model_win(w, h, off, r, c);
    e.row  = 3'(r / s);
    e.col  = 3'(c / s);
    e.last = (i == n - 1);
    return e;
  endfunction

  function automatic logic [WB-1:0] win9(int a0, int a1, int a2, int a3, int a4,
                                         int a5, int a6, int a7, int a8);
    logic [WB-1:0] v;
    v[0*DW +: DW] = DW'(a0); v[1*DW +: DW] = DW'(a1); v[2*DW +: DW] = DW'(a2);
    v[3*DW +: DW] = DW'(a3); v[4*DW +: DW] = DW'(a4); v[5*DW +: DW] = DW'(a5);
    v[6*DW +: DW] = DW'(a6); v[7*DW +: DW] = DW'(a7); v[8*DW +: DW] = DW'(a8);
    return v;
  endfunction

  // Streams one frame into instance d and records what comes out.
  // Starts at a falling edge; drives and samples between edges.
  task automatic run_frame(input int d, input int w, input int h, input int off,
                           input int stall, input bit gaps, input int n_exp);
    int   px, cyc, stall_cnt, post, run;
    cap_t cp;
    stl_t sp;
    cap_q.delete();
    stl_q.delete();
    timed_out = 0; fd_cnt = 0; rdy_low = 0; rdy_run_max = 0;
    px = 0; cyc = 0; stall_cnt = 0; post = 0; run = 0;
    while (post < 12) begin
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
      if (px < w * h) begin
        iv[d]     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        i_data[d] = DW'(off + 10 * (px / w) + px % w);
      end else begin
        iv[d]     = 1'b0;
        i_data[d] = '0;
      end
      if (ov[d] && stall_cnt < stall) begin
        ordy[d] = 1'b0;
        stall_cnt++;
      end else begin
        ordy[d] = 1'b1;
      end
      #1;
      if (fdone[d]) fd_cnt++;
      if (!ir[d]) begin
        rdy_low++;
        run++;
        if (run > rdy_run_max) rdy_run_max = run;
      end else begin
        run = 0;
      end
      if (ov[d] && !ordy[d]) begin
        sp.data = o_data[d]; sp.rdy = ir[d]; sp.idx = cap_q.size();
        stl_q.push_back(sp);
      end
      if (ov[d] && ordy[d]) begin
        cp.data = o_data[d]; cp.row = o_row[d]; cp.col = o_col[d]; cp.last = olast[d];
        cap_q.push_back(cp);
        stall_cnt = 0;
      end
      if (iv[d] && ir[d]) px++;
      if (cap_q.size() >= n_exp) post++;
      cyc++;
      @(negedge clk);
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ov !== 3'b000) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 000", ov); end
    n_cmp++; if (o_data[0] !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", o_data[0]); end
    n_cmp++; if (o_row[0] !== 3'd0 || o_col[0] !== 3'd0) begin n_bad++; $display("FAIL reset_row_col: got %0d,%0d expected 0,0", o_row[0], o_col[0]); end
    n_cmp++; if (olast !== 3'b000) begin n_bad++; $display("FAIL reset_out_last: got %b expected 000", olast); end
    n_cmp++; if (fdone !== 3'b000) begin n_bad++; $display("FAIL reset_frame_done: got %b expected 000", fdone); end
    n_cmp++; if (ir !== 3'b111) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 111", ir); end
    @(negedge clk);
  endtask

  task automatic test_stride1();
    cap_t e;
    run_frame(0, 4, 4, 0, 0, 1'b0, 16);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL s1_timeout: got %0d windows expected 16", cap_q.size()); end
    n_cmp++; if (cap_q.size() != 16) begin n_bad++; $display("FAIL s1_count: got %0d expected 16", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 16; i++) begin
      e = exp_cap(4, 4, 1, 0, i, 16);
      n_cmp++;
      if (cap_q[i].data !== e.data || cap_q[i].row !== e.row || cap_q[i].col !== e.col || cap_q[i].last !== e.last) begin
        n_bad++;
        $display("FAIL s1_win%0d: got %h r%0d c%0d l%b expected %h r%0d c%0d l%b", i,
                 cap_q[i].data, cap_q[i].row, cap_q[i].col, cap_q[i].last, e.data, e.row, e.col, e.last);
      end
    end
    if (cap_q.size() == 16) begin
      n_cmp++; if (cap_q[0].data !== win9(0,0,0,0,0,1,0,10,11)) begin n_bad++; $display("FAIL s1_first: got %h", cap_q[0].data); end
      n_cmp++; if (cap_q[15].data !== win9(22,23,0,32,33,0,0,0,0) || cap_q[15].last !== 1'b1) begin n_bad++; $display("FAIL s1_last: got %h l%b", cap_q[15].data, cap_q[15].last); end
    end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL s1_frame_done: got %0d pulses expected 1", fd_cnt); end
  endtask

  task automatic test_stride2();
    cap_t e;
    run_frame(1, 4, 4, 0, 0, 1'b0, 4);
    n_cmp++; if (cap_q.size() != 4 || timed_out) begin n_bad++; $display("FAIL s2_count: got %0d expected 4", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      e = exp_cap(4, 4, 2, 0, i, 4);
      n_cmp++;
      if (cap_q[i].data !== e.data || cap_q[i].row !== e.row || cap_q[i].col !== e.col || cap_q[i].last !== e.last) begin
        n_bad++;
        $display("FAIL s2_win%0d: got %h r%0d c%0d l%b expected %h r%0d c%0d l%b", i,
                 cap_q[i].data, cap_q[i].row, cap_q[i].col, cap_q[i].last, e.data, e.row, e.col, e.last);
      end
    end
    if (cap_q.size() == 4) begin
      n_cmp++; if (cap_q[3].data !== win9(11,12,13,21,22,23,31,32,33)) begin n_bad++; $display("FAIL s2_win22: got %h", cap_q[3].data); end
    end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL s2_frame_done: got %0d pulses expected 1", fd_cnt); end
  endtask

  task automatic test_back_pressure();
    cap_t e;
    logic [WB-1:0] ew;
    run_frame(0, 4, 4, 0, 3, 1'b0, 16);
    n_cmp++; if (cap_q.size() != 16 || timed_out) begin n_bad++; $display("FAIL bp_count: got %0d expected 16", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 16; i++) begin
      e = exp_cap(4, 4, 1, 0, i, 16);
      n_cmp++;
      if (cap_q[i].data !== e.data || cap_q[i].row !== e.row || cap_q[i].col !== e.col || cap_q[i].last !== e.last) begin
        n_bad++;
        $display("FAIL bp_win%0d: got %h expected %h", i, cap_q[i].data, e.data);
      end
    end
    n_cmp++; if (stl_q.size() != 48) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d expected 48", stl_q.size()); end
    for (int i = 0; i < stl_q.size(); i++) begin
      ew = model_win(4, 4, 0, stl_q[i].idx / 4, stl_q[i].idx % 4);
      n_cmp++;
      if (stl_q[i].data !== ew || stl_q[i].rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got %h in_ready=%b expected %h in_ready=0", i, stl_q[i].data, stl_q[i].rdy, ew);
      end
    end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL bp_frame_done: got %0d pulses expected 1", fd_cnt); end
  endtask

  task automatic test_input_gaps();
    cap_t e;
    run_frame(2, 5, 3, 0, 0, 1'b1, 15);
    n_cmp++; if (cap_q.size() != 15 || timed_out) begin n_bad++; $display("FAIL gap_count: got %0d expected 15", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 15; i++) begin
      e = exp_cap(5, 3, 1, 0, i, 15);
      n_cmp++;
      if (cap_q[i].data !== e.data || cap_q[i].row !== e.row || cap_q[i].col !== e.col || cap_q[i].last !== e.last) begin
        n_bad++;
        $display("FAIL gap_win%0d: got %h r%0d c%0d l%b expected %h r%0d c%0d l%b", i,
                 cap_q[i].data, cap_q[i].row, cap_q[i].col, cap_q[i].last, e.data, e.row, e.col, e.last);
      end
    end
    n_cmp++; if (rdy_low != 9) begin n_bad++; $display("FAIL gap_in_ready_low: got %0d cycles expected 9", rdy_low); end
    n_cmp++; if (rdy_run_max != 7) begin n_bad++; $display("FAIL gap_pad_row_run: got %0d expected 7", rdy_run_max); end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL gap_frame_done: got %0d pulses expected 1", fd_cnt); end
  endtask

  task automatic test_vs();
    int   px, cyc;
    cap_t e;
    px = 0; cyc = 0;
    ordy[0] = 1'b1;
    while (px < 9 && cyc < 200) begin
      iv[0]     = 1'b1;
      i_data[0] = DW'(10 * (px / 4) + px % 4);
      #1;
      if (ir[0]) px++;
      cyc++;
      @(negedge clk);
    end
    ordy[0]   = 1'b0;
    iv[0]     = 1'b1;
    i_data[0] = DW'(21);
    cyc = 0;
    #1;
    while (!(ov[0] && !ir[0]) && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    n_cmp++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL vs_pending: got out_valid=%b expected 1", ov[0]); end
    n_cmp++;
    if (o_data[0] !== model_win(4, 4, 0, 1, 0) || o_row[0] !== 3'd1 || o_col[0] !== 3'd0) begin
      n_bad++;
      $display("FAIL vs_pending_win: got %h r%0d c%0d expected %h r1 c0", o_data[0], o_row[0], o_col[0], model_win(4, 4, 0, 1, 0));
    end
    vs_v[0]   = 1'b1;
    i_data[0] = DW'(8'hEE);
    #1;
    n_cmp++; if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL vs_in_ready: got %b expected 0", ir[0]); end
    @(negedge clk);
    #1;
    n_cmp++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL vs_drop: got out_valid=%b expected 0", ov[0]); end
    n_cmp++; if (o_data[0] !== '0 || olast[0] !== 1'b0) begin n_bad++; $display("FAIL vs_clear: got %h l%b expected 0", o_data[0], olast[0]); end
    vs_v[0] = 1'b0;
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    run_frame(0, 4, 4, 100, 0, 1'b0, 16);
    n_cmp++; if (cap_q.size() != 16 || timed_out) begin n_bad++; $display("FAIL vs_new_count: got %0d expected 16", cap_q.size()); end
    if (cap_q.size() > 0) begin
      n_cmp++;
      if (cap_q[0].data !== win9(0,0,0,0,100,101,0,110,111)) begin n_bad++; $display("FAIL vs_new_first: got %h", cap_q[0].data); end
    end
    for (int i = 0; i < cap_q.size() && i < 16; i++) begin
      e = exp_cap(4, 4, 1, 100, i, 16);
      n_cmp++;
      if (cap_q[i].data !== e.data || cap_q[i].row !== e.row || cap_q[i].col !== e.col || cap_q[i].last !== e.last) begin
        n_bad++;
        $display("FAIL vs_new_win%0d: got %h expected %h", i, cap_q[i].data, e.data);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    vs_v = 3'b000;
    iv   = 3'b000;
    ordy = 3'b111;
    for (int d = 0; d < 3; d++) i_data[d] = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_stride1();
    test_stride2();
    test_back_pressure();
    test_input_gaps();
    test_vs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
